// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-RAM port between the CPU MEM stage (port C) and a
// DMA/loader master (port D). At most one RAM access issues per cycle, and a
// latency tag pipe routes each read's returning data back to its requester.
// While the MEM-stage access is unfinished, cpu_stall holds the pipeline.
//
// Parameters:
//   AW          address width
//   DW          data width
//   RD_LAT      RAM read latency in cycles (1..3)
//   STARVE_MAX  consecutive refusals of a pending DMA request before it is
//               granted over the CPU (1..255)
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata             MEM-stage access request
//   cpu_rdata, cpu_rvalid             load return (one-cycle pulse)
//   cpu_stall                         hold PC/IF/ID/EX/MEM stages
//   dma_req/we/addr/wdata             DMA access request (held until dma_gnt)
//   dma_gnt                           DMA access accepted this cycle
//   dma_rdata, dma_rvalid             DMA read return (one-cycle pulse)
//   ram_en/we/addr/wdata              RAM access strobe and command
//   ram_rdata                         RAM read data, RD_LAT cycles after issue
//   perf_stall_cnt, perf_dma_cnt      performance counters
//
// Optional feature (macro DMEM_ARB_PERF_EN):
//   When defined, perf_stall_cnt counts cycles with cpu_stall=1 and
//   perf_dma_cnt counts DMA grants; both are 32-bit wrapping counters cleared
//   by rst. When undefined, both ports are tied to zero and no counter flops
//   exist.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_stall,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,

  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,

  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_dma_cnt
);

  typedef enum logic {
    C_IDLE = 1'b0,
    C_WAIT = 1'b1
  } cpu_state_t;

  localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

  cpu_state_t        cpu_state;
  logic [7:0]        starve_cnt;

  // Tag pipe: stage 0 receives the tag of this cycle's access, stage
  // RD_LAT-1 is the tag whose data is on ram_rdata right now.
  logic [RD_LAT-1:0] tag_valid;
  logic [RD_LAT-1:0] tag_src_cpu;

  logic              c_eligible;
  logic              d_starved;
  logic              c_win;
  logic              d_win;
  logic              rd_issue;
  logic              tag_exit;
  logic              cpu_ret;
  logic              dma_ret;

  // Arbitration. The CPU owns the port whenever it can issue, unless the DMA
  // has been refused STARVE_MAX cycles in a row. Nothing is granted while rst
  // is high so every output reads zero during reset.
  always_comb begin
    c_eligible = cpu_req && (cpu_state == C_IDLE);
    d_starved  = (starve_cnt == STARVE_LIMIT);
    d_win      = !rst && dma_req && (!c_eligible || d_starved);
    c_win      = !rst && c_eligible && !d_win;
    rd_issue   = (c_win && !cpu_we) || (d_win && !dma_we);
  end

  // Winner's command onto the RAM port; idle port drives all zeros.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (c_win) begin
      ram_en    = 1'b1;
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (d_win) begin
      ram_en    = 1'b1;
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
  end

  assign dma_gnt = d_win;

  // Return routing. The exiting tag is suppressed during rst so a read that
  // was in flight when reset arrived never produces a pulse.
  always_comb begin
    tag_exit   = tag_valid[RD_LAT-1] && !rst;
    cpu_ret    = tag_exit && tag_src_cpu[RD_LAT-1];
    dma_ret    = tag_exit && !tag_src_cpu[RD_LAT-1];
    cpu_rvalid = cpu_ret;
    dma_rvalid = dma_ret;
    cpu_rdata  = cpu_ret ? ram_rdata : '0;
    dma_rdata  = dma_ret ? ram_rdata : '0;
  end

  // Stall is combinational so the MEM->WB register can capture load data on
  // the very edge it returns. In C_IDLE only a granted store finishes in the
  // same cycle; a granted load or a refused request must hold the pipeline.
  always_comb begin
    cpu_stall = 1'b0;
    if (!rst) begin
      if (cpu_state == C_WAIT) begin
        cpu_stall = !cpu_ret;
      end else begin
        cpu_stall = cpu_req && !(c_win && cpu_we);
      end
    end
  end

  // CPU access FSM. In C_WAIT the request is still held by the stalled
  // pipeline and is deliberately ignored until the load tag exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_state <= C_IDLE;
    end else begin
      case (cpu_state)
        C_IDLE: if (c_win && !cpu_we) cpu_state <= C_WAIT;
        C_WAIT: if (cpu_ret)          cpu_state <= C_IDLE;
        default:                      cpu_state <= C_IDLE;
      endcase
    end
  end

  // Consecutive-refusal counter for a waiting DMA request; saturates so the
  // forced grant keeps winning until it is actually taken.
  always_ff @(posedge clk) begin
    if (rst || !dma_req || d_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Latency tag shift register. Writes and idle cycles push an invalid tag
  // so every read's tag reaches the exit stage exactly RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid   <= '0;
      tag_src_cpu <= '0;
    end else begin
      tag_valid[0]   <= rd_issue;
      tag_src_cpu[0] <= c_win && !cpu_we;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid[i]   <= tag_valid[i-1];
        tag_src_cpu[i] <= tag_src_cpu[i-1];
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Free-running performance counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_dma_cnt   <= '0;
    end else begin
      if (cpu_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (d_win)     perf_dma_cnt   <= perf_dma_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_dma_cnt   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Randomised scoreboard bench for dmem_arbiter. The stimulus task drives one
// cycle of CPU/DMA requests, predicts that cycle's arbitration outcome from
// the priority/starvation rules, and pushes the expected port state plus any
// expected read returns (data and due cycle) into queues. A monitor process
// at each falling edge pops and compares against the DUT. A RAM model with
// RD_LAT read latency serves the DUT's RAM port.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int RD_LAT     = 3;
  localparam int STARVE_MAX = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid, cpu_stall;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [31:0]   perf_stall_cnt, perf_dma_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
  );

  // RAM model: 128 words indexed by addr[8:2], read data RD_LAT cycles late;
  // cycles without a read shift in random garbage.
  logic [31:0] ram_mem [0:127];
  logic [31:0] rd_dly  [0:RD_LAT-1];
  assign ram_rdata = rd_dly[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr[8:2]] <= ram_wdata;
    rd_dly[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[8:2]] : $urandom;
    for (int i = 1; i < RD_LAT; i++) rd_dly[i] <= rd_dly[i-1];
  end

  typedef struct {
    bit          rst_cyc;
    bit          en;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          gnt;
    bit          stall;
    logic [31:0] ps;
    logic [31:0] pd;
  } cyc_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } ret_exp_t;

  cyc_exp_t exp_q[$];
  ret_exp_t cpu_ret_q[$];
  ret_exp_t dma_ret_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference state: memory contents, outstanding agent operations, and the
  // cycle number at which an outstanding CPU load is due back (-1 if none).
  logic [31:0] ref_mem [0:127];
  bit          cpu_has = 0, cpu_op_we = 0;
  logic [31:0] cpu_op_addr = '0, cpu_op_wdata = '0;
  bit          dma_has = 0, dma_op_we = 0;
  logic [31:0] dma_op_addr = '0, dma_op_wdata = '0;
  int          ret_cycle  = -1;
  int          refused    = 0;
  int          last_cload = -10;
  logic [31:0] perf_s = '0, perf_d = '0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, act, expv);
    end
  endtask

  function automatic logic [31:0] randAddr(input bit region_b);
    logic [31:0] a;
    a      = $urandom;
    a[8]   = region_b;
    a[1:0] = 2'b00;
    return a;
  endfunction

  // One clock cycle: start new agent operations, drive inputs, predict.
  task automatic applyStimulus(input int cpu_pct, input int cpu_we_pct,
                               input int dma_pct, input int dma_we_pct,
                               input bit do_rst);
    cyc_exp_t e;
    bit c_elig, d_win, c_win, cpu_returning;
    @(posedge clk);
    #1;
    cycle++;
    if (!cpu_has && int'($urandom_range(99)) < cpu_pct) begin
      cpu_has      = 1;
      cpu_op_we    = int'($urandom_range(99)) < cpu_we_pct;
      cpu_op_addr  = randAddr(1'b0);
      cpu_op_wdata = $urandom;
    end
    if (!dma_has && int'($urandom_range(99)) < dma_pct) begin
      dma_has      = 1;
      dma_op_we    = int'($urandom_range(99)) < dma_we_pct;
      dma_op_addr  = randAddr(1'b1);
      dma_op_wdata = $urandom;
    end
    rst       = do_rst;
    cpu_req   = cpu_has;
    cpu_we    = cpu_op_we;
    cpu_addr  = cpu_op_addr;
    cpu_wdata = cpu_op_wdata;
    dma_req   = dma_has;
    dma_we    = dma_op_we;
    dma_addr  = dma_op_addr;
    dma_wdata = dma_op_wdata;

    e = '{default: '0};
    if (do_rst) begin
      e.rst_cyc = 1;
      exp_q.push_back(e);
      cpu_ret_q.delete();
      dma_ret_q.delete();
      cpu_has   = 0;
      dma_has   = 0;
      ret_cycle = -1;
      refused   = 0;
      perf_s    = '0;
      perf_d    = '0;
      return;
    end

    c_elig        = cpu_has && (ret_cycle < 0);
    d_win         = dma_has && (!c_elig || refused == STARVE_MAX);
    c_win         = c_elig && !d_win;
    cpu_returning = (ret_cycle == cycle);
    if (ret_cycle >= 0) e.stall = !cpu_returning;
    else                e.stall = cpu_has && !(c_win && cpu_op_we);
    e.gnt = d_win;
    if (c_win) begin
      e.en = 1; e.we = cpu_op_we; e.addr = cpu_op_addr; e.wdata = cpu_op_wdata;
    end else if (d_win) begin
      e.en = 1; e.we = dma_op_we; e.addr = dma_op_addr; e.wdata = dma_op_wdata;
    end
`ifdef DMEM_ARB_PERF_EN
    e.ps = perf_s;
    e.pd = perf_d;
`endif
    exp_q.push_back(e);

    if (e.stall) perf_s = perf_s + 1;
    if (d_win) begin
      perf_d  = perf_d + 1;
      refused = 0;
      if (dma_op_we) ref_mem[dma_op_addr[8:2]] = dma_op_wdata;
      else dma_ret_q.push_back('{data: ref_mem[dma_op_addr[8:2]], due: cycle + RD_LAT});
      dma_has = 0;
    end else if (dma_has) begin
      if (refused < STARVE_MAX) refused++;
    end else begin
      refused = 0;
    end
    if (cpu_returning) begin
      cpu_has   = 0;
      ret_cycle = -1;
    end
    if (c_win) begin
      if (cpu_op_we) begin
        ref_mem[cpu_op_addr[8:2]] = cpu_op_wdata;
        cpu_has = 0;
      end else begin
        cpu_ret_q.push_back('{data: ref_mem[cpu_op_addr[8:2]], due: cycle + RD_LAT});
        ret_cycle  = cycle + RD_LAT;
        last_cload = cycle;
      end
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued expectation and
  // match read returns against the scoreboard by due cycle.
  always @(negedge clk) begin
    cyc_exp_t e;
    ret_exp_t r;
    bit exp_cv, exp_dv;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("ram_en",    {31'd0, ram_en},    {31'd0, e.en});
      checkOutput("ram_we",    {31'd0, ram_we},    {31'd0, e.we});
      checkOutput("dma_gnt",   {31'd0, dma_gnt},   {31'd0, e.gnt});
      checkOutput("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
      if (e.en) begin
        checkOutput("ram_addr",  ram_addr,  e.addr);
        checkOutput("ram_wdata", ram_wdata, e.wdata);
      end
      if (e.rst_cyc) begin
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("rst_dma_rdata", dma_rdata, 32'd0);
        checkOutput("rst_ram_addr",  ram_addr,  32'd0);
      end else begin
        checkOutput("perf_stall_cnt", perf_stall_cnt, e.ps);
        checkOutput("perf_dma_cnt",   perf_dma_cnt,   e.pd);
      end
      exp_cv = (cpu_ret_q.size() > 0) && (cpu_ret_q[0].due == cycle);
      exp_dv = (dma_ret_q.size() > 0) && (dma_ret_q[0].due == cycle);
      checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, exp_cv});
      checkOutput("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, exp_dv});
      if (exp_cv) begin
        r = cpu_ret_q.pop_front();
        if (cpu_rvalid) checkOutput("cpu_rdata", cpu_rdata, r.data);
      end
      if (exp_dv) begin
        r = dma_ret_q.pop_front();
        if (dma_rvalid) checkOutput("dma_rdata", dma_rdata, r.data);
      end
    end
  end

  initial begin
    logic [31:0] v;
    bit want_rst;
    for (int i = 0; i < 128; i++) begin
      v = $urandom;
      ram_mem[i] <= v;
      ref_mem[i]  = v;
    end
    $display("[TB] start RD_LAT=%0d STARVE_MAX=%0d", RD_LAT, STARVE_MAX);

    // Reset, then idle
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1'b0);

    // CPU streams stores while DMA always waits: forced grants
    for (int i = 0; i < 40; i++) applyStimulus(100, 100, 100, 50, 1'b0);

    // Random mix with resets landing one cycle after a CPU load issues
    want_rst = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 400 || i == 900 || i == 1300) want_rst = 1;
      if (want_rst && last_cload == cycle) begin
        applyStimulus(60, 50, 50, 50, 1'b1);
        want_rst = 0;
      end else begin
        applyStimulus(60, 50, 50, 50, 1'b0);
      end
    end

    // Back-to-back DMA reads interleaved with CPU loads
    for (int i = 0; i < 300; i++) applyStimulus(30, 0, 100, 0, 1'b0);

    // Drain: no new operations, let everything complete
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 0, 0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("drain_pending",
                32'(cpu_ret_q.size() + dma_ret_q.size() + exp_q.size()
                    + int'(cpu_has) + int'(dma_has)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
